// File: rtl/tuner_search_ctrl.sv
// rtl/tuner_search_ctrl.sv - ring tuner search initiator: trigger, peak capture, qualified peak select, retry
// Optional WAIT watchdog enabled by defining TUNER_SEARCH_CTRL_TIMEOUT_EN.
module tuner_search_ctrl #(
  parameter int DAC_WIDTH      = 8,
  parameter int ADC_WIDTH      = 8,
  parameter int NUM_TARGET     = 4,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_ctrl_start,
  input  logic [$clog2(NUM_TARGET)-1:0]   i_ctrl_target_idx,
  input  logic [ADC_WIDTH-1:0]            i_ctrl_min_pwr,
  input  logic [DAC_WIDTH-1:0]            i_cfg_tune_start,
  input  logic [DAC_WIDTH-1:0]            i_cfg_tune_end,
  input  logic [DAC_WIDTH-1:0]            i_cfg_tune_stride,
  output logic [DAC_WIDTH-1:0]            o_dig_ring_tune_start,
  output logic [DAC_WIDTH-1:0]            o_dig_ring_tune_end,
  output logic [DAC_WIDTH-1:0]            o_dig_ring_tune_stride,
  output logic                            o_dig_search_trig_val,
  input  logic                            i_dig_search_trig_rdy,
  input  logic                            i_dig_search_peaks_val,
  output logic                            o_dig_search_peaks_rdy,
  input  logic [NUM_TARGET*DAC_WIDTH-1:0] i_dig_ring_tune_peaks,
  input  logic [NUM_TARGET*ADC_WIDTH-1:0] i_dig_pwr_detected_peaks,
  input  logic [$clog2(NUM_TARGET):0]     i_dig_ring_tune_peaks_cnt,
  output logic [DAC_WIDTH-1:0]            o_dig_lock_tune,
  output logic [ADC_WIDTH-1:0]            o_dig_lock_pwr,
  output logic                            o_ctrl_busy,
  output logic                            o_ctrl_done,
  output logic                            o_ctrl_fail,
  output logic [1:0]                      o_ctrl_fail_code,
  output logic [$clog2(MAX_RETRY+1)-1:0]  o_mon_retry_cnt,
  output logic [2:0]                      o_mon_state
);

  localparam int IDX_W = $clog2(NUM_TARGET);
  localparam int CNT_W = IDX_W + 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TRIG   = 3'd1,
    S_WAIT   = 3'd2,
    S_SELECT = 3'd3,
    S_DONE   = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t                          state_q, state_d;
  logic [DAC_WIDTH-1:0]            tune_start_q, tune_start_d;
  logic [DAC_WIDTH-1:0]            tune_end_q, tune_end_d;
  logic [DAC_WIDTH-1:0]            tune_stride_q, tune_stride_d;
  logic [IDX_W-1:0]                target_idx_q, target_idx_d;
  logic [ADC_WIDTH-1:0]            min_pwr_q, min_pwr_d;
  logic [NUM_TARGET*DAC_WIDTH-1:0] peak_tune_q, peak_tune_d;
  logic [NUM_TARGET*ADC_WIDTH-1:0] peak_pwr_q, peak_pwr_d;
  logic [CNT_W-1:0]                peak_cnt_q, peak_cnt_d;
  logic [DAC_WIDTH-1:0]            lock_tune_q, lock_tune_d;
  logic [ADC_WIDTH-1:0]            lock_pwr_q, lock_pwr_d;
  logic [RTY_W-1:0]                retry_q, retry_d;
  logic [1:0]                      fail_code_q, fail_code_d;

  logic                            sel_found;
  logic [DAC_WIDTH-1:0]            sel_tune;
  logic [ADC_WIDTH-1:0]            sel_pwr;
  logic [CNT_W-1:0]                qual_cnt;
  logic                            wait_timeout;

`ifdef TUNER_SEARCH_CTRL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

  // Counter sits at zero outside WAIT, so every WAIT entry starts a fresh window.
  always_comb begin
    wait_cnt_d   = '0;
    wait_timeout = 1'b0;
    if (state_q == S_WAIT) begin
      wait_cnt_d   = wait_cnt_q + TO_W'(1);
      wait_timeout = (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) wait_cnt_q <= '0;
    else          wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wait_timeout       = 1'b0;
`endif

  // Walk slots in scan order; the (target_idx+1)-th qualifying slot wins.
  always_comb begin
    sel_found = 1'b0;
    sel_tune  = '0;
    sel_pwr   = '0;
    qual_cnt  = '0;
    for (int i = 0; i < NUM_TARGET; i++) begin
      if ((CNT_W'(i) < peak_cnt_q) &&
          (peak_pwr_q[i*ADC_WIDTH +: ADC_WIDTH] >= min_pwr_q)) begin
        if (!sel_found && (qual_cnt == {1'b0, target_idx_q})) begin
          sel_found = 1'b1;
          sel_tune  = peak_tune_q[i*DAC_WIDTH +: DAC_WIDTH];
          sel_pwr   = peak_pwr_q[i*ADC_WIDTH +: ADC_WIDTH];
        end
        qual_cnt = qual_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    tune_start_d  = tune_start_q;
    tune_end_d    = tune_end_q;
    tune_stride_d = tune_stride_q;
    target_idx_d  = target_idx_q;
    min_pwr_d     = min_pwr_q;
    peak_tune_d   = peak_tune_q;
    peak_pwr_d    = peak_pwr_q;
    peak_cnt_d    = peak_cnt_q;
    lock_tune_d   = lock_tune_q;
    lock_pwr_d    = lock_pwr_q;
    retry_d       = retry_q;
    fail_code_d   = fail_code_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_ctrl_start) begin
          tune_start_d  = i_cfg_tune_start;
          tune_end_d    = i_cfg_tune_end;
          tune_stride_d = i_cfg_tune_stride;
          target_idx_d  = i_ctrl_target_idx;
          min_pwr_d     = i_ctrl_min_pwr;
          retry_d       = '0;
          fail_code_d   = 2'd0;
          state_d       = S_TRIG;
        end
      end
      S_TRIG: begin
        if (i_dig_search_trig_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_dig_search_peaks_val) begin
          peak_tune_d = i_dig_ring_tune_peaks;
          peak_pwr_d  = i_dig_pwr_detected_peaks;
          peak_cnt_d  = (i_dig_ring_tune_peaks_cnt > CNT_W'(NUM_TARGET)) ?
                        CNT_W'(NUM_TARGET) : i_dig_ring_tune_peaks_cnt;
          state_d     = S_SELECT;
        end else if (wait_timeout) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_TRIG;
          end else begin
            fail_code_d = 2'd2;
            state_d     = S_FAIL;
          end
        end
      end
      S_SELECT: begin
        if (sel_found) begin
          lock_tune_d = sel_tune;
          lock_pwr_d  = sel_pwr;
          state_d     = S_DONE;
        end else if (retry_q < RTY_W'(MAX_RETRY)) begin
          retry_d = retry_q + RTY_W'(1);
          state_d = S_TRIG;
        end else begin
          fail_code_d = 2'd1;
          state_d     = S_FAIL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      tune_start_q  <= '0;
      tune_end_q    <= '0;
      tune_stride_q <= '0;
      target_idx_q  <= '0;
      min_pwr_q     <= '0;
      peak_tune_q   <= '0;
      peak_pwr_q    <= '0;
      peak_cnt_q    <= '0;
      lock_tune_q   <= '0;
      lock_pwr_q    <= '0;
      retry_q       <= '0;
      fail_code_q   <= 2'd0;
    end else begin
      state_q       <= state_d;
      tune_start_q  <= tune_start_d;
      tune_end_q    <= tune_end_d;
      tune_stride_q <= tune_stride_d;
      target_idx_q  <= target_idx_d;
      min_pwr_q     <= min_pwr_d;
      peak_tune_q   <= peak_tune_d;
      peak_pwr_q    <= peak_pwr_d;
      peak_cnt_q    <= peak_cnt_d;
      lock_tune_q   <= lock_tune_d;
      lock_pwr_q    <= lock_pwr_d;
      retry_q       <= retry_d;
      fail_code_q   <= fail_code_d;
    end
  end

  assign o_dig_ring_tune_start  = tune_start_q;
  assign o_dig_ring_tune_end    = tune_end_q;
  assign o_dig_ring_tune_stride = tune_stride_q;
  assign o_dig_search_trig_val  = (state_q == S_TRIG);
  assign o_dig_search_peaks_rdy = (state_q == S_WAIT);
  assign o_dig_lock_tune        = lock_tune_q;
  assign o_dig_lock_pwr         = lock_pwr_q;
  assign o_ctrl_busy            = (state_q != S_IDLE);
  assign o_ctrl_done            = (state_q == S_DONE);
  assign o_ctrl_fail            = (state_q == S_FAIL);
  assign o_ctrl_fail_code       = fail_code_q;
  assign o_mon_retry_cnt        = retry_q;
  assign o_mon_state            = state_q;

endmodule
